arm_fetch_stage: RTL and testbench

//  Producer side of the fetch interface that the top level exposes as pc_out / instruction_memory_out.

---
 rtl/arm_pkg.sv | 14 +
 rtl/arm_fetch_stage_if.sv | 23 ++
 rtl/arm_fetch_stage_rom.sv | 25 ++
 rtl/arm_fetch_stage.sv | 93 +++++++++
 tb/tb_arm_fetch_stage.sv | 122 ++++++++++++
 5 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM core front end: word geometry and fetch FSM states.
package arm_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef enum logic [1:0] {
        FS_BOOT,
        FS_RUN,
        FS_STALL
    } fetch_state_t;

endpackage

// File: rtl/arm_fetch_stage_if.sv
// Fetch-to-decode interface: stall/redirect from later stages, IF/ID latch toward decode.
interface arm_fetch_stage_if;
    import arm_pkg::*;

    logic                freeze;
    logic                branch_taken;
    logic [WORD_W-1:0]   branch_addr;
    logic [WORD_W-1:0]   pc_out;
    logic [WORD_W-1:0]   instruction_memory_out;
    logic                if_valid;
    logic [15:0]         fetch_count;

    modport master (
        input  freeze, branch_taken, branch_addr,
        output pc_out, instruction_memory_out, if_valid, fetch_count
    );

    modport slave (
        output freeze, branch_taken, branch_addr,
        input  pc_out, instruction_memory_out, if_valid, fetch_count
    );

endinterface

// File: rtl/arm_fetch_stage_rom.sv
// Instruction ROM with combinational word-addressed read; words past the end read as NOP.
module arm_instr_rom
    import arm_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 64,
    parameter              INIT_FILE  = "instr.mem"
) (
    input  logic [WORD_W-3:0] word_addr_i,
    output logic [WORD_W-1:0] data_o
);

    localparam int unsigned AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam logic [WORD_W-3:0] DEPTH = (WORD_W-2)'(IMEM_WORDS);

    // Image named by INIT_FILE is loaded into mem by the surrounding environment.
    logic [WORD_W-1:0] mem [IMEM_WORDS];

    always_comb begin
        data_o = NOP_INSTR;
        if (word_addr_i < DEPTH) begin
            data_o = mem[word_addr_i[AW-1:0]];
        end
    end

endmodule

// File: rtl/arm_fetch_stage.sv
// Fetch stage: PC register, boot/run/stall FSM, and the IF/ID latch feeding decode.
module arm_fetch_stage
    import arm_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 64,
    parameter              INIT_FILE  = "instr.mem"
) (
    input  logic              clk,
    input  logic              rst,
    arm_fetch_stage_if.master fif
);

    fetch_state_t      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] pc_out_q, pc_out_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic [15:0]       cnt_q, cnt_d;

    logic [WORD_W-1:0] rom_data;
    logic [WORD_W-1:0] pc_plus4;
    logic [WORD_W-1:0] target;

    arm_instr_rom #(
        .IMEM_WORDS (IMEM_WORDS),
        .INIT_FILE  (INIT_FILE)
    ) u_rom (
        .word_addr_i (pc_q[WORD_W-1:2]),
        .data_o      (rom_data)
    );

    assign pc_plus4 = pc_q + PC_STEP;
    assign target   = {fif.branch_addr[WORD_W-1:2], 2'b00};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;

        // A redirect overrides both the boot bubble and any pending stall.
        if (fif.branch_taken) begin
            pc_d     = target;
            pc_out_d = '0;
            instr_d  = NOP_INSTR;
            valid_d  = 1'b0;
            state_d  = FS_RUN;
        end else begin
            case (state_q)
                FS_BOOT: state_d = FS_RUN;
                default: begin
                    if (fif.freeze) begin
                        state_d = FS_STALL;
                    end else begin
                        pc_d     = pc_plus4;
                        pc_out_d = pc_plus4;
                        instr_d  = rom_data;
                        valid_d  = 1'b1;
                        if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
                        state_d  = FS_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FS_BOOT;
            pc_q     <= RESET_PC;
            pc_out_q <= '0;
            instr_q  <= NOP_INSTR;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign fif.pc_out                 = pc_out_q;
    assign fif.instruction_memory_out = instr_q;
    assign fif.if_valid               = valid_q;
    assign fif.fetch_count            = cnt_q;

endmodule

// File: tb/tb_arm_fetch_stage.sv
// Self-checking bench for arm_fetch_stage: expected IF/ID contents queued per cycle, compared after each edge.
module tb_arm_fetch_stage;
    import arm_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        v;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    arm_fetch_stage_if fif ();

    arm_fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (64),
        .INIT_FILE  ("instr.mem")
    ) dut (
        .clk (clk),
        .rst (rst),
        .fif (fif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected result, then compare after the edge.
    task automatic step(input logic r, input logic frz, input logic br, input logic [31:0] addr,
                        input logic [31:0] e_pc, input logic [31:0] e_ins, input logic e_v,
                        input logic [15:0] e_cnt);
        exp_t e;
        rst              = r;
        fif.freeze       = frz;
        fif.branch_taken = br;
        fif.branch_addr  = addr;
        e.pc = e_pc; e.ins = e_ins; e.v = e_v; e.cnt = e_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check("pc_out", 64'(fif.pc_out), 64'(e.pc));
            check("instr", 64'(fif.instruction_memory_out), 64'(e.ins));
            check("if_valid", 64'(fif.if_valid), 64'(e.v));
            check("fetch_count", 64'(fif.fetch_count), 64'(e.cnt));
        end
    endtask

    initial begin
        logic [31:0] img [8];
        img[0] = 32'd11; img[1] = 32'd22; img[2] = 32'd33; img[3] = 32'd44;
        img[4] = 32'd55; img[5] = 32'd66; img[6] = 32'd77; img[7] = 32'd88;
        for (int i = 0; i < 64; i++) dut.u_rom.mem[i] = (i < 8) ? img[i] : 32'h0;

        rst = 1'b1; fif.freeze = 1'b0; fif.branch_taken = 1'b0; fif.branch_addr = '0;

        // Reset, boot bubble, straight-line fetch with a 3-cycle freeze at pc_out=8
        step(1, 0, 0, 0, 32'h0, 32'd0, 0, 0);
        check("reset_state", 64'(dut.state_q), 64'(FS_BOOT));
        step(0, 0, 0, 0, 32'h0, 32'd0, 0, 0);
        check("boot_pc_hold", 64'(dut.pc_q), 64'h0);
        step(0, 0, 0, 0, 32'h4, 32'd11, 1, 1);
        step(0, 0, 0, 0, 32'h8, 32'd22, 1, 2);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 32'h8, 32'd22, 1, 2);
        check("stall_state", 64'(dut.state_q), 64'(FS_STALL));
        step(0, 0, 0, 0, 32'hC, 32'd33, 1, 3);
        step(0, 0, 0, 0, 32'h10, 32'd44, 1, 4);

        // Misaligned branch: flush, then target instruction
        step(0, 0, 1, 32'h13, 32'h0, 32'd0, 0, 4);
        check("branch_pc", 64'(dut.pc_q), 64'h10);
        step(0, 0, 0, 0, 32'h14, 32'd55, 1, 5);
        step(0, 0, 0, 0, 32'h18, 32'd66, 1, 6);

        // Branch and freeze together while stalled
        step(0, 1, 0, 0, 32'h18, 32'd66, 1, 6);
        step(0, 1, 1, 32'h13, 32'h0, 32'd0, 0, 6);
        check("brfrz_state", 64'(dut.state_q), 64'(FS_RUN));
        step(0, 0, 0, 0, 32'h14, 32'd55, 1, 7);

        // Out-of-range fetch and PC wrap
        step(0, 0, 1, 32'h100, 32'h0, 32'd0, 0, 7);
        step(0, 0, 0, 0, 32'h104, 32'd0, 1, 8);
        step(0, 0, 1, 32'hFFFF_FFFC, 32'h0, 32'd0, 0, 8);
        step(0, 0, 0, 0, 32'h0, 32'd0, 1, 9);
        step(0, 0, 0, 0, 32'h4, 32'd11, 1, 10);

        // Reset during a stall at pc=0x20
        step(0, 0, 1, 32'h20, 32'h0, 32'd0, 0, 10);
        step(0, 1, 0, 0, 32'h0, 32'd0, 0, 10);
        check("stall_pc", 64'(dut.pc_q), 64'h20);
        step(1, 1, 0, 0, 32'h0, 32'd0, 0, 0);
        check("rst_pc", 64'(dut.pc_q), 64'h0);
        check("rst_state", 64'(dut.state_q), 64'(FS_BOOT));

        // Branch during the boot bubble
        step(0, 0, 1, 32'h10, 32'h0, 32'd0, 0, 0);
        check("boot_br_state", 64'(dut.state_q), 64'(FS_RUN));
        check("boot_br_pc", 64'(dut.pc_q), 64'h10);
        step(0, 0, 0, 0, 32'h14, 32'd55, 1, 1);
        step(0, 0, 0, 0, 32'h18, 32'd66, 1, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
